// File: rtl/demux_dispatch_1to4.sv
// -----------------------------------------------------------------------------
// demux_dispatch_1to4
//
// Purpose:
//   Routes a single valid/ready upstream stream to one of four downstream
//   channels. Each channel owns a one-entry holding register (valid + data)
//   that drives its output directly, so every accepted beat appears one cycle
//   after acceptance. A channel that is being drained can be reloaded in the
//   same cycle, so back-to-back beats to one channel flow without bubbles.
//   Channels drain independently: a stalled channel only blocks beats that
//   target it.
//
// Configuration:
//   DEMUX_DISPATCH_AUTO_SEL_EN
//     undefined (default) : target channel is in_sel.
//     defined             : in_sel is ignored; a 2-bit round-robin pointer
//                           picks the target and advances only on an
//                           accepted beat. A full target is waited on, never
//                           skipped.
//
// Ports:
//   clk        in   1        clock, all state updates on the rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        upstream beat present
//   in_data    in   WIDTH    upstream payload
//   in_sel     in   2        destination channel 0..3
//   in_ready   out  1        beat accepted this cycle (combinational)
//   out_valid  out  4        bit k = channel k holds a beat
//   out_data   out  4*WIDTH  channel k payload at [k*WIDTH +: WIDTH]
//   out_ready  in   4        per-channel downstream accept
//   beat_cnt   out  8        accepted-beat counter, wraps 255 -> 0
// -----------------------------------------------------------------------------

module demux_dispatch_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic                 in_ready,
    output logic [3:0]           out_valid,
    output logic [4*WIDTH-1:0]   out_data,
    input  logic [3:0]           out_ready,
    output logic [7:0]           beat_cnt
);

    localparam int N_CH = 4;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [1:0]        w_target;        // channel the current beat goes to
    logic              w_accept;        // handshake completes this cycle
    logic [N_CH-1:0]   w_load;          // one-hot write enable per channel
    logic [N_CH-1:0]   w_drain;         // per-channel downstream handshake

    logic [N_CH-1:0]   r_valid;
    logic [WIDTH-1:0]  r_data [N_CH];
    logic [7:0]        r_beat_cnt;

    // -------------------------------------------------------------------------
    // Target selection
    // -------------------------------------------------------------------------
`ifdef DEMUX_DISPATCH_AUTO_SEL_EN
    logic [1:0] r_ptr;
    logic       w_unused_sel;

    // in_sel has no function in this build; folded here so it is not flagged.
    assign w_unused_sel = ^in_sel;

    // The pointer only moves on an accepted beat, so a full channel stalls
    // the stream until it drains rather than being skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_accept) begin
            r_ptr <= r_ptr + 2'd1;
        end
    end

    assign w_target = r_ptr;
`else
    assign w_target = in_sel;
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // The target can take a beat if it is empty or is emptying this cycle.
    // Gating with rst keeps beats from being lost into a register that the
    // same edge is about to clear.
    assign in_ready = (~r_valid[w_target] | out_ready[w_target]) & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_valid & out_ready;

    always_comb begin
        // NOTE: default every always_comb output before any conditional
        // assignment; a path that leaves it unassigned infers a latch.
        w_load = '0;
        if (w_accept) begin
            w_load[w_target] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel holding registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order; blocking (=) is used only
    // in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            // NOTE: the data registers are reset too because the outputs must
            // read zero after reset; without that requirement they could be
            // left unreset, since valid alone qualifies them.
            for (int k = 0; k < N_CH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_load[k]) begin
                    // Load wins over a simultaneous drain: valid stays high
                    // and the new beat replaces the one being consumed.
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (w_drain[k]) begin
                    // Data is left untouched so the output holds its last
                    // value while idle.
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accepted-beat counter (natural 8-bit wrap)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= 8'd0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = r_valid;
    assign beat_cnt  = r_beat_cnt;

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

endmodule

// File: tb/tb_demux_dispatch_1to4.sv
// -----------------------------------------------------------------------------
// tb_demux_dispatch_1to4
//
// Self-checking bench for demux_dispatch_1to4 (WIDTH = 8). Stimulus pushes the
// expected payload of every beat it expects to be accepted onto the queue of
// the channel it should land in; an independent monitor pops and compares
// whenever a channel completes a downstream handshake. Status outputs
// (out_valid, in_ready, beat_cnt, held data) are checked directly against
// hand-computed values. Define DEMUX_DISPATCH_AUTO_SEL_EN for both the RTL
// and this bench to exercise the round-robin build.
// -----------------------------------------------------------------------------

module tb_demux_dispatch_1to4;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_ready;
    logic [3:0]     out_valid;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_ready;
    logic [7:0]     beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q [4][$];

    demux_dispatch_1to4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one downstream transfer per channel per valid&ready cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL ch%0d unexpected beat: got 0x%0h expected none",
                                 k, out_data[k*W +: W]);
                    end else begin
                        check($sformatf("ch%0d data", k), 32'(out_data[k*W +: W]),
                              32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    // Samples in_ready at the negedge; a beat expected to be accepted is
    // queued for the channel it should reach.
    task automatic accept_chk(input string name, input logic exp_rdy,
                              input int ch, input logic [W-1:0] d);
        @(negedge clk);
        check(name, 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy) exp_q[ch].push_back(d);
    endtask

    function automatic logic [W-1:0] slice(input int k);
        return out_data[k*W +: W];
    endfunction

    // One-cycle reset from anywhere; buffered beats are dropped unseen.
    task automatic do_reset(input string tag);
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, " in_ready during rst"}, 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_data"},  out_data,       32'd0);
        check({tag, " beat_cnt"},  32'(beat_cnt),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;

        step();
        step();
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data",  out_data,       32'd0);
        check("reset beat_cnt",  32'(beat_cnt),  32'd0);
        check("reset in_ready",  32'(in_ready),  32'd0);
        step();
        rst = 1'b0;

`ifndef DEMUX_DISPATCH_AUTO_SEL_EN
        // ---- First beat right after reset, held with out_ready low ----
        drive(1'b1, 2'd2, 8'hA5);
        accept_chk("first beat in_ready", 1'b1, 2, 8'hA5);
        step();
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        check("first beat out_valid", 32'(out_valid), 32'b0100);
        check("first beat slice2",    32'(slice(2)),  32'hA5);
        check("first beat beat_cnt",  32'(beat_cnt), 32'd1);
        step();
        out_ready = 4'b0100;
        @(negedge clk);
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain slice2 held", 32'(slice(2)), 32'hA5);

        // ---- Full channel 1 stalls, then drain and reload in one cycle ----
        step();
        drive(1'b1, 2'd1, 8'h31);
        accept_chk("ch1 load in_ready", 1'b1, 1, 8'h31);
        step();
        drive(1'b1, 2'd1, 8'h32);
        accept_chk("ch1 full in_ready", 1'b0, 1, 8'h32);
        check("ch1 full slice1", 32'(slice(1)), 32'h31);
        check("ch1 full out_valid", 32'(out_valid), 32'b0010);
        step();
        out_ready = 4'b0010;
        accept_chk("ch1 drain in_ready", 1'b1, 1, 8'h32);
        step();
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 4'b0000;
        @(negedge clk);
        check("ch1 reload out_valid", 32'(out_valid), 32'b0010);
        check("ch1 reload slice1",    32'(slice(1)),  32'h32);
        check("ch1 reload beat_cnt",  32'(beat_cnt),  32'd3);
        step();
        out_ready = 4'b0010;
        @(negedge clk);
        step();
        out_ready = 4'b0000;

        // ---- Back-to-back beats to channels 0..3, all draining ----
        do_reset("b2b reset");
        for (int i = 0; i < 4; i++) begin
            step();
            out_ready = 4'b1111;
            drive(1'b1, 2'(i), 8'h10 + 8'(i));
            accept_chk("b2b in_ready", 1'b1, i, 8'h10 + 8'(i));
            if (i > 0) check("b2b out_valid", 32'(out_valid), 32'(4'b0001 << (i - 1)));
        end
        step();
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        check("b2b out_valid last", 32'(out_valid), 32'b1000);
        step();
        @(negedge clk);
        check("b2b out_valid idle", 32'(out_valid), 32'd0);
        check("b2b beat_cnt",       32'(beat_cnt),  32'd4);

        // ---- 256 beats: counter wraps ----
        do_reset("wrap reset");
        for (int i = 0; i < 256; i++) begin
            step();
            out_ready = 4'b1111;
            drive(1'b1, 2'(i), 8'(i));
            @(negedge clk);
            exp_q[i % 4].push_back(8'(i));
            if (i == 255) check("wrap beat_cnt 255", 32'(beat_cnt), 32'd255);
        end
        step();
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        check("wrap beat_cnt 0", 32'(beat_cnt), 32'd0);
        step();
        out_ready = 4'b0000;

        // ---- Channels 0 and 3 full; idle input noise; then reset ----
        drive(1'b1, 2'd0, 8'hC0);
        accept_chk("ch0 load in_ready", 1'b1, 0, 8'hC0);
        step();
        drive(1'b1, 2'd3, 8'hC3);
        accept_chk("ch3 load in_ready", 1'b1, 3, 8'hC3);
        step();
        drive(1'b0, 2'd2, 8'hFF);
        @(negedge clk);
        step();
        drive(1'b0, 2'd1, 8'h5A);
        @(negedge clk);
        check("idle noise out_valid", 32'(out_valid), 32'b1001);
        check("idle noise beat_cnt",  32'(beat_cnt),  32'd2);
        check("idle noise slice0",    32'(slice(0)),  32'hC0);
        check("idle noise slice2",    32'(slice(2)),  32'hFE);
        check("idle noise slice3",    32'(slice(3)),  32'hC3);
        do_reset("mid reset");
        step();
        drive(1'b1, 2'd3, 8'h77);
        accept_chk("post reset in_ready", 1'b1, 3, 8'h77);
        step();
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 4'b1000;
        @(negedge clk);
        step();
        out_ready = 4'b0000;
`else
        // ---- Round-robin order with in_sel held at 0 ----
        for (int i = 0; i < 5; i++) begin
            step();
            out_ready = 4'b1111;
            drive(1'b1, 2'd0, 8'h20 + 8'(i));
            accept_chk("rr in_ready", 1'b1, i % 4, 8'h20 + 8'(i));
            if (i > 0) check("rr out_valid", 32'(out_valid), 32'(4'b0001 << ((i - 1) % 4)));
        end
        step();
        drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        check("rr out_valid last", 32'(out_valid), 32'b0001);
        check("rr beat_cnt",       32'(beat_cnt),  32'd5);
        step();
        out_ready = 4'b0000;

        // ---- Pointer waits on a full channel instead of skipping ----
        do_reset("rr reset");
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 2'(3 - i), 8'h40 + 8'(i));
            accept_chk("rr fill in_ready", 1'b1, i, 8'h40 + 8'(i));
        end
        step();
        drive(1'b1, 2'd1, 8'h44);
        accept_chk("rr all full in_ready", 1'b0, 0, 8'h44);
        step();
        out_ready = 4'b0010;
        accept_chk("rr no skip in_ready", 1'b0, 0, 8'h44);
        step();
        out_ready = 4'b0001;
        accept_chk("rr ch0 drain in_ready", 1'b1, 0, 8'h44);
        step();
        drive(1'b0, 2'd0, 8'h00);
        out_ready = 4'b0000;
        @(negedge clk);
        check("rr stall out_valid", 32'(out_valid), 32'b1101);
        check("rr stall slice0",    32'(slice(0)),  32'h44);
        step();
        out_ready = 4'b1111;
        @(negedge clk);
        step();
        out_ready = 4'b0000;
`endif

        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ch%0d queue empty", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_1to4.md
DEMUX_DISPATCH_1TO4 -- requirements
Module: demux_dispatch_1to4

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, payload bits per beat.
REQ-002 The block SHALL have the port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have the port: rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have the port: in_valid  input  1  upstream beat present.
REQ-005 The block SHALL have the port: in_data  input  WIDTH  upstream payload.
REQ-006 The block SHALL have the port: in_sel  input  2  destination channel 0..3.
REQ-007 The block SHALL have the port: in_ready  output  1  block accepts the beat this cycle.
REQ-008 The block SHALL have the port: out_valid  output  4  per-channel beat present, bit k = channel k.
REQ-009 The block SHALL have the port: out_data  output  4*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have the port: out_ready  input  4  per-channel downstream accept.
REQ-011 The block SHALL have the port: beat_cnt  output  8  accepted-beat counter, wraps 255->0.

Function
REQ-012 The target channel T SHALL be in_sel when AUTO_SEL_EN is undefined, and the rotation pointer when it is defined.
REQ-013 Each channel SHALL hold a single-entry register (valid bit + WIDTH data) driving out_valid[k]/out_data slice k directly.
REQ-014 in_ready SHALL be combinational: (~out_valid[T] | out_ready[T]) & ~rst.
REQ-015 A beat SHALL be accepted when in_valid & in_ready; on acceptance channel T loads in_data and sets valid at the next edge, giving 1-cycle latency.
REQ-016 Channel k SHALL clear valid at the edge where out_valid[k] & out_ready[k] and no load to k occurs.
REQ-017 On simultaneous drain and load of the same channel, the load SHALL win: valid stays 1, data becomes the new beat, and no bubble is inserted.
REQ-018 A full, non-draining target SHALL hold in_ready=0; the other channels SHALL continue to drain independently (no head-of-line effect on their outputs).
REQ-019 out_data slice k SHALL hold its last value while valid=0; no glitch or clearing occurs on drain.
REQ-020 beat_cnt SHALL increment by 1 per accepted beat and wrap from 255 to 0.
REQ-021 Only the target channel SHALL be written per cycle; at most one beat is accepted per cycle.
REQ-022 in_data/in_sel changes while in_valid=0 SHALL have no effect on any state.

Reset
REQ-023 While rst=1 at an edge: out_valid=4'b0000, all out_data slices=0, beat_cnt=0, rotation pointer=0.
REQ-024 Reset mid-operation SHALL discard all buffered beats without emitting them; in_ready=0 during any cycle with rst=1.
REQ-025 The first beat SHALL be acceptable in the first cycle after rst falls.

Configuration
REQ-026 Macro DEMUX_DISPATCH_AUTO_SEL_EN SHALL control target selection.
REQ-027 With DEMUX_DISPATCH_AUTO_SEL_EN defined: in_sel is ignored; a 2-bit pointer selects T and increments (3->0 wrap) only on an accepted beat; while the pointed channel is full, in_ready=0 and the pointer does not skip it.
REQ-028 With DEMUX_DISPATCH_AUTO_SEL_EN undefined: no pointer is instantiated and T=in_sel.

Verification
REQ-029 Bench SHALL cover: reset then in_valid=1, in_sel=2, in_data=8'hA5, out_ready=0 -> next cycle out_valid=4'b0100, slice 2=8'hA5, beat_cnt=1.
REQ-030 Bench SHALL cover: channel 1 full, out_ready[1]=0, new beat to sel=1 -> in_ready=0, data unchanged; raise out_ready[1] -> beat accepted the same cycle, slice 1 updated at the next edge, out_valid[1] stays 1.
REQ-031 Bench SHALL cover: beats 8'h10..8'h13 to sel 0..3 back-to-back, out_ready=4'b1111 -> each out_valid bit pulses for one cycle, one cycle after its input, beat_cnt=4.
REQ-032 Bench SHALL cover: 256 accepted beats -> beat_cnt wraps to 0.
REQ-033 Bench SHALL cover: channels 0 and 3 full, rst=1 for one cycle -> out_valid=0, out_data=0, beat_cnt=0 after the edge.
REQ-034 Bench SHALL cover (AUTO_SEL_EN defined): 5 beats with in_sel held at 0, out_ready=4'b1111 -> channels receive them in order 0,1,2,3,0.
